// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-segment driver: scans NUM_DIGITS anodes with a guard gap per slot,
// double-buffered data that changes only at frame boundaries, and leading-zero suppression.
module seg7_scan_mux #(
    parameter int NUM_DIGITS   = 8,
    parameter int SLOT_CYCLES  = 100000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              z,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]        slot_cnt, slot_nxt;
    logic [IDX_W-1:0]        digit_idx, idx_nxt;
    logic [4*NUM_DIGITS-1:0] pend_val, disp_val, disp_val_nxt;
    logic [NUM_DIGITS-1:0]   pend_dp, disp_dp, disp_dp_nxt;
    logic [NUM_DIGITS-1:0]   pend_blank, disp_blank, disp_blank_nxt;
    logic                    pend_flag;
    logic                    shown, shown_nxt;
    logic                    slot_wrap, frame_wrap, transfer;

    logic [NUM_DIGITS-1:0]   lz_mask;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_blank, cur_lz;
    logic                    guard, seg_off;
    logic                    zero_above;
    logic [NUM_DIGITS-1:0]   an_d;
    logic [6:0]              z_d;
    logic                    dp_d, frame_done_d;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Outputs are decoded from next-state values so the registered pins line up with the counters.
    always_comb begin
        slot_wrap      = (slot_cnt == SLOT_LAST);
        frame_wrap     = slot_wrap && (digit_idx == IDX_LAST);
        slot_nxt       = slot_wrap ? '0 : slot_cnt + CNT_W'(1);
        idx_nxt        = digit_idx;
        if (slot_wrap) begin
            idx_nxt = (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
        end
        transfer       = frame_wrap && pend_flag;
        disp_val_nxt   = transfer ? pend_val   : disp_val;
        disp_dp_nxt    = transfer ? pend_dp    : disp_dp;
        disp_blank_nxt = transfer ? pend_blank : disp_blank;
        shown_nxt      = shown || transfer;
    end

    // Digit k is a leading zero when it and every digit above it are zero; digit 0 is exempt.
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (disp_val_nxt[4*k +: 4] == 4'h0);
            if (k != 0) begin
                lz_mask[k] = zero_above;
            end
        end
    end

    always_comb begin
        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_lz    = 1'b0;
        an_sel    = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_nxt == IDX_W'(k)) begin
                cur_nib   = disp_val_nxt[4*k +: 4];
                cur_dp    = disp_dp_nxt[k];
                cur_blank = disp_blank_nxt[k];
                cur_lz    = lz_mask[k];
                an_sel[k] = 1'b0;
            end
        end
        guard        = (slot_nxt < GUARD_END) || !shown_nxt;
        seg_off      = guard || cur_blank;
        an_d         = guard ? '1 : an_sel;
        z_d          = (seg_off || (lz_en && cur_lz)) ? 7'h7F : seg_decode(cur_nib);
        dp_d         = seg_off ? 1'b1 : ~cur_dp;
        frame_done_d = (slot_nxt == SLOT_LAST) && (idx_nxt == IDX_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt   <= '0;
            digit_idx  <= '0;
            pend_flag  <= 1'b0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '1;
            disp_val   <= '0;
            disp_dp    <= '0;
            disp_blank <= '1;
            shown      <= 1'b0;
            an         <= '1;
            z          <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            slot_cnt   <= slot_nxt;
            digit_idx  <= idx_nxt;
            if (load) begin
                pend_val   <= value;
                pend_dp    <= dp_in;
                pend_blank <= blank_in;
            end
            // A load landing on the boundary stays pending while the older capture moves out.
            pend_flag  <= load || (pend_flag && !frame_wrap);
            disp_val   <= disp_val_nxt;
            disp_dp    <= disp_dp_nxt;
            disp_blank <= disp_blank_nxt;
            shown      <= shown_nxt;
            an         <= an_d;
            z          <= z_d;
            dp         <= dp_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: stimulus queues per-frame expectations, a negedge
// monitor rebuilds each observed frame and compares it when frame_done closes it.
module tb_seg7_scan_mux;

    localparam int N  = 4;
    localparam int SC = 4;
    localparam int GC = 1;

    localparam logic [6:0] Z0   = 7'b1000000;
    localparam logic [6:0] Z1   = 7'b1111001;
    localparam logic [6:0] Z2   = 7'b0100100;
    localparam logic [6:0] Z3   = 7'b0110000;
    localparam logic [6:0] Z4   = 7'b0011001;
    localparam logic [6:0] Z5   = 7'b0010010;
    localparam logic [6:0] Z8   = 7'b0000000;
    localparam logic [6:0] Z9   = 7'b0010000;
    localparam logic [6:0] ZA   = 7'b0001000;
    localparam logic [6:0] ZB   = 7'b0000011;
    localparam logic [6:0] ZOFF = 7'b1111111;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4*N-1:0] value = '0;
    logic          load = 1'b0;
    logic [N-1:0]  dp_in = '0;
    logic [N-1:0]  blank_in = '0;
    logic          lz_en = 1'b0;
    logic [N-1:0]  an;
    logic [6:0]    z;
    logic          dp;
    logic          frame_done;

    always #5 clk = ~clk;

    seg7_scan_mux #(
        .NUM_DIGITS  (N),
        .SLOT_CYCLES (SC),
        .GUARD_CYCLES(GC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .load      (load),
        .dp_in     (dp_in),
        .blank_in  (blank_in),
        .lz_en     (lz_en),
        .an        (an),
        .z         (z),
        .dp        (dp),
        .frame_done(frame_done)
    );

    typedef struct {
        int              fno;
        bit              shown;
        logic [3:0][6:0] zs;
        logic [3:0]      dps;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push_exp(input int f, input bit sh, input logic [3:0][6:0] zs, input logic [3:0] d);
        exp_t e;
        e.fno   = f;
        e.shown = sh;
        e.zs    = zs;
        e.dps   = d;
        exp_q.push_back(e);
    endtask

    // Monitor state for the frame currently being observed.
    int         fno = 0;
    int         cyc = 0;
    int         off_cnt = 0;
    int         bad_cnt = 0;
    int         act_cnt [4];
    logic [6:0] z_seen [4];
    logic       dp_seen [4];

    task automatic clear_frame();
        cyc     = 0;
        off_cnt = 0;
        bad_cnt = 0;
        for (int k = 0; k < N; k++) begin
            act_cnt[k] = 0;
            z_seen[k]  = 'x;
            dp_seen[k] = 1'bx;
        end
    endtask

    task automatic finish_frame();
        exp_t e;
        check($sformatf("f%0d_len", fno), cyc, 16);
        while (exp_q.size() > 0 && exp_q[0].fno < fno) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_missed: got frame %0d expected frame %0d", fno, exp_q[0].fno);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].fno == fno) begin
            e = exp_q.pop_front();
            check($sformatf("f%0d_off_cycles", fno), off_cnt, e.shown ? 4 : 16);
            check($sformatf("f%0d_bad_cycles", fno), bad_cnt, 0);
            for (int k = 0; k < N; k++) begin
                check($sformatf("f%0d_d%0d_active", fno, k), act_cnt[k], e.shown ? 3 : 0);
                if (e.shown) begin
                    check($sformatf("f%0d_d%0d_z", fno, k), z_seen[k], e.zs[k]);
                    check($sformatf("f%0d_d%0d_dp", fno, k), dp_seen[k], e.dps[k]);
                end
            end
        end
        clear_frame();
        fno++;
    endtask

    always @(negedge clk) begin
        logic [3:0] pat;
        bit         found;
        if (rst) begin
            clear_frame();
            fno = 0;
        end else begin
            cyc++;
            if (an === 4'hF) begin
                off_cnt++;
                if (z !== ZOFF || dp !== 1'b1) bad_cnt++;
            end else begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    pat    = 4'hF;
                    pat[k] = 1'b0;
                    if (an === pat) begin
                        found = 1'b1;
                        if (act_cnt[k] > 0 && (z !== z_seen[k] || dp !== dp_seen[k])) bad_cnt++;
                        act_cnt[k]++;
                        z_seen[k]  = z;
                        dp_seen[k] = dp;
                    end
                end
                if (!found) bad_cnt++;
            end
            if (frame_done === 1'b1) begin
                finish_frame();
            end else if (cyc >= 64) begin
                n_cmp++;
                n_bad++;
                $display("FAIL frame_timeout: got %0d cycles without frame_done expected 16", cyc);
                clear_frame();
            end
        end
    end

    task automatic sync_frame_end();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 64);
        if (frame_done !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sync_timeout: got frame_done %b expected 1 within 64 cycles", frame_done);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value    = v;
        dp_in    = d;
        blank_in = b;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, an, 4'hF);
        check({tag, "_z"}, z, ZOFF);
        check({tag, "_dp"}, dp, 1'b1);
        check({tag, "_frame_done"}, frame_done, 1'b0);
    endtask

    initial begin
        int f;
        int n;
        push_exp(0, 1'b0, '0, 4'hF);
        push_exp(1, 1'b0, '0, 4'hF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Hex decode across all four digits.
        sync_frame_end();
        f = fno;
        do_load(16'h89AB, 4'b0000, 4'b0000);
        push_exp(f + 1, 1'b1, {Z8, Z9, ZA, ZB}, 4'hF);

        // Mid-frame load must not tear the frame showing 89AB.
        sync_frame_end();
        f = fno;
        wait_cycles(6);
        do_load(16'h1234, 4'b0000, 4'b0000);
        push_exp(f + 1, 1'b1, {Z1, Z2, Z3, Z4}, 4'hF);

        // Leading-zero suppression.
        sync_frame_end();
        f = fno;
        lz_en = 1'b1;
        do_load(16'h0050, 4'b0000, 4'b0000);
        push_exp(f + 1, 1'b1, {ZOFF, ZOFF, Z5, Z0}, 4'hF);

        sync_frame_end();
        f = fno;
        do_load(16'h0000, 4'b0000, 4'b0000);
        push_exp(f + 1, 1'b1, {ZOFF, ZOFF, ZOFF, Z0}, 4'hF);

        // Decimal point and forced blank.
        sync_frame_end();
        f = fno;
        do_load(16'h1234, 4'b0100, 4'b0001);
        push_exp(f + 1, 1'b1, {Z1, Z2, Z3, ZOFF}, 4'b1011);

        // Suppressed zero keeps its decimal point.
        sync_frame_end();
        f = fno;
        do_load(16'h0000, 4'b0100, 4'b0000);
        push_exp(f + 1, 1'b1, {ZOFF, ZOFF, ZOFF, Z0}, 4'b1011);

        // Back-to-back loads: last one wins.
        sync_frame_end();
        f = fno;
        do_load(16'h1111, 4'b0000, 4'b0000);
        do_load(16'h2345, 4'b0000, 4'b0000);
        push_exp(f + 1, 1'b1, {Z2, Z3, Z4, Z5}, 4'hF);

        // Load on the boundary cycle stays pending one more frame.
        sync_frame_end();
        f = fno;
        do_load(16'h1111, 4'b0000, 4'b0000);
        wait_cycles(14);
        do_load(16'h4444, 4'b0000, 4'b0000);
        push_exp(f + 1, 1'b1, {Z1, Z1, Z1, Z1}, 4'hF);
        push_exp(f + 2, 1'b1, {Z4, Z4, Z4, Z4}, 4'hF);

        // Reset during digit 2 with a load pending.
        sync_frame_end();
        sync_frame_end();
        do_load(16'h9999, 4'b0000, 4'b0000);
        wait_cycles(8);
        check("queue_empty_before_reset", exp_q.size(), 0);
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        push_exp(0, 1'b0, '0, 4'hF);
        push_exp(1, 1'b0, '0, 4'hF);
        @(posedge clk);
        #1 rst = 1'b0;

        sync_frame_end();
        f = fno;
        do_load(16'h89AB, 4'b0000, 4'b0000);
        push_exp(f + 1, 1'b1, {Z8, Z9, ZA, ZB}, 4'hF);

        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
